rls_iter_sched: RTL

- Sequencer that drives one Updatex engine through ITER recursive least-squares iterations.
- Per iteration it requests coefficient row idx (b, k, a) from external storage and waits for that row.
- It then pulses the engine reset, waits the fixed engine latency, captures x, and feeds x back as the next x0.
- It replaces hard-wired per-iteration register slicing with an addressed fetch and a start/busy/done handshake, so coefficient storage can sit in block RAM.

---
 rtl/rls_iter_sched_pkg.sv | 22 ++
 rtl/rls_iter_sched_if.sv | 31 +++
 rtl/rls_iter_sched_lat_counter.sv | 27 ++
 rtl/rls_iter_sched.sv | 109 ++++++++++
 4 files changed

// File: rtl/rls_iter_sched_pkg.sv
// Shared types and elaboration helpers for the RLS iteration sequencer.
package rls_iter_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_KICK    = 3'd2,
        ST_RUN     = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // Engine cycles from reset release to a valid result; the engine wrapper uses the same formula.
    function automatic int calc_lat(input int size, input int combsize);
        return 1 + 3 * (1 + size / combsize);
    endfunction

    function automatic int idx_width(input int iter);
        return (iter > 1) ? $clog2(iter) : 1;
    endfunction

endpackage

// File: rtl/rls_iter_sched_if.sv
// Control, row-fetch and engine connections of the RLS iteration sequencer.
interface rls_iter_sched_if #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 16,
    parameter int IDXW  = 5
);
    logic                    start;
    logic                    abort;
    logic [WIDTH*SIZE-1:0]   x0;
    logic                    row_req;
    logic [IDXW-1:0]         iter_idx;
    logic                    row_valid;
    logic                    eng_reset;
    logic [WIDTH*SIZE-1:0]   eng_x0;
    logic [WIDTH*SIZE-1:0]   eng_x;
    logic [WIDTH*SIZE-1:0]   x;
    logic                    busy;
    logic                    iter_strobe;
    logic                    done;

    modport master (
        output start, abort, x0, row_valid, eng_x,
        input  row_req, iter_idx, eng_reset, eng_x0, x, busy, iter_strobe, done
    );

    modport slave (
        input  start, abort, x0, row_valid, eng_x,
        output row_req, iter_idx, eng_reset, eng_x0, x, busy, iter_strobe, done
    );

endinterface

// File: rtl/rls_iter_sched_lat_counter.sv
// Up counter that times the engine run window; expire marks its final cycle.
module rls_lat_counter #(
    parameter int LAT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int CW = $clog2(LAT + 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expire_o = (count_q == CW'(LAT - 1));

endmodule

// File: rtl/rls_iter_sched.sv
// Sequences ITER recursive least-squares iterations through one Updatex engine,
// fetching each coefficient row by address and feeding every result back as the next x0.
module rls_iter_sched
    import rls_iter_sched_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 16,
    parameter int COMBSIZE = 4,
    parameter int ITER     = 32
) (
    input logic             clk_i,
    input logic             rst_i,
    rls_iter_sched_if.slave bus
);
    localparam int LAT  = calc_lat(SIZE, COMBSIZE);
    localparam int IDXW = idx_width(ITER);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ITER - 1);

    state_e                state_q, state_d;
    logic [IDXW-1:0]       iter_idx_q;
    logic [WIDTH*SIZE-1:0] x_q;
    logic [WIDTH*SIZE-1:0] eng_x0_q;
    logic                  row_req_q;
    logic                  eng_reset_q;
    logic                  busy_q;
    logic                  iter_strobe_q;
    logic                  done_q;
    logic                  run_expire;

    rls_lat_counter #(.LAT(LAT)) u_run_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (state_q == ST_KICK),
        .en_i     (state_q == ST_RUN),
        .expire_o (run_expire)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (bus.start) state_d = ST_FETCH;
            ST_FETCH:   if (bus.row_valid) state_d = ST_KICK;
            ST_KICK:    state_d = ST_RUN;
            ST_RUN:     if (run_expire) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = (iter_idx_q == LAST_IDX) ? ST_DONE : ST_FETCH;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        // Abort beats everything, including a start arriving in IDLE.
        if (bus.abort) begin
            state_d = ST_IDLE;
        end
    end

    // row_req and eng_reset follow the next state so they line up with the state itself;
    // busy, iter_strobe and done report the state just left, alongside the x update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            iter_idx_q    <= '0;
            x_q           <= '0;
            eng_x0_q      <= '0;
            row_req_q     <= 1'b0;
            eng_reset_q   <= 1'b1;
            busy_q        <= 1'b0;
            iter_strobe_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_req_q     <= (state_d == ST_FETCH);
            eng_reset_q   <= (state_d == ST_IDLE) || (state_d == ST_KICK);
            busy_q        <= (state_q != ST_IDLE) && !bus.abort;
            iter_strobe_q <= (state_q == ST_CAPTURE) && !bus.abort;
            done_q        <= (state_q == ST_DONE) && !bus.abort;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        eng_x0_q   <= bus.x0;
                        iter_idx_q <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (!bus.abort) begin
                        x_q      <= bus.eng_x;
                        eng_x0_q <= bus.eng_x;
                        if (iter_idx_q != LAST_IDX) begin
                            iter_idx_q <= iter_idx_q + 1'b1;
                        end
                    end
                end
                ST_DONE: iter_idx_q <= '0;
                default: ;
            endcase
            if (bus.abort) begin
                iter_idx_q <= '0;
            end
        end
    end

    assign bus.row_req     = row_req_q;
    assign bus.iter_idx    = iter_idx_q;
    assign bus.eng_reset   = eng_reset_q;
    assign bus.eng_x0      = eng_x0_q;
    assign bus.x           = x_q;
    assign bus.busy        = busy_q;
    assign bus.iter_strobe = iter_strobe_q;
    assign bus.done        = done_q;

endmodule
